// File: rtl/enc_event_packer.sv
// enc_event_packer: absorbs encoder edge events in a small FIFO and emits
// them as 64-bit AXI-Stream beats with tlast every PACKET_LEN beats.
// Events arriving while the FIFO is full are discarded and counted.
module enc_event_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 256
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [63:0]                   s_axis_tdata,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [63:0]                   m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          drop_clear,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] OCC_FULL  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BEAT_LAST = 16'(PACKET_LEN - 1);
  localparam logic [31:0]   DROP_MAX  = 32'hFFFF_FFFF;

  // Each entry keeps the full input word plus tuser; bit 63 of tdata is
  // replaced by tuser on the way out.
  logic [64:0]   mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [15:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;

  logic full;
  logic wr_en;
  logic rd_en;
  logic drop;
  logic [64:0] head;

  // Full is judged on registered occupancy, so a same-cycle read never
  // makes room for a write.
  assign full  = (occ_q == OCC_FULL);
  assign wr_en = s_axis_tvalid && !full;
  assign drop  = s_axis_tvalid && full;
  assign rd_en = m_axis_tvalid && m_axis_tready;
  assign head  = mem_q[rd_ptr_q];

  // Next-state computation for pointers, occupancy, beat and drop counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (rd_en) begin
      beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? 16'd0 : beat_cnt_q + 16'd1;
    end

    // A clear coinciding with a drop counts that drop as the first of the new run.
    if (drop_clear) begin
      drop_cnt_d = drop ? 32'd1 : 32'd0;
    end else if (drop && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      beat_cnt_q <= beat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Event storage write port.
  // NOTE: storage is not reset; entries are only read once occupancy marks them valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tdata};
  end

  // Outputs derive only from registered state (first-word-fall-through head).
  always_comb begin
    s_axis_tready = !full;
    m_axis_tvalid = (occ_q != '0);
    m_axis_tdata  = {head[64], head[62:0]};
    m_axis_tlast  = (beat_cnt_q == BEAT_LAST) && m_axis_tvalid;
    drop_count    = drop_cnt_q;
    fifo_level    = occ_q;
  end

endmodule

// File: tb/tb_enc_event_packer.sv
// tb_enc_event_packer: directed and randomized-ready checks for
// enc_event_packer with FIFO_DEPTH=16 and PACKET_LEN=4.
module tb_enc_event_packer;

  localparam int DEPTH = 16;
  localparam int PLEN  = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        drop_clear = 1'b0;
  logic [31:0] drop_count;
  logic [4:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;

  enc_event_packer #(.FIFO_DEPTH(DEPTH), .PACKET_LEN(PLEN)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .drop_clear    (drop_clear),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    drop_clear    = 1'b0;
    aresetn       = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    int beats;
    logic [63:0] q[$];
    int occ;
    int sent;
    int drops;
    logic prev_stall;
    logic [63:0] prev_data;
    logic pop;

    // ---- Reset state ----
    do_reset();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    check("rst_level",  64'(fifo_level),    64'd0);
    check("rst_drops",  64'(drop_count),    64'd0);

    // ---- Single event, no pass-through, one cycle latency ----
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h0000_0000_0000_1234;
    s_axis_tuser  = 1'b1;
    m_axis_tready = 1'b1;
    check("single_no_passthru", 64'(m_axis_tvalid), 64'd0);
    step();
    s_axis_tvalid = 1'b0;
    check("single_valid", 64'(m_axis_tvalid), 64'd1);
    check("single_data",  m_axis_tdata, 64'h8000_0000_0000_1234);
    check("single_level1", 64'(fifo_level), 64'd1);
    step();
    check("single_level0", 64'(fifo_level), 64'd0);
    check("single_empty",  64'(m_axis_tvalid), 64'd0);

    // ---- 20 events into a stalled sink: 16 stored, 4 dropped ----
    do_reset();
    s_axis_tuser = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(i);
      step();
      check($sformatf("fill_tready_%0d", i), 64'(s_axis_tready), (i < 16) ? 64'd1 : 64'd0);
    end
    s_axis_tvalid = 1'b0;
    check("fill_drops", 64'(drop_count), 64'd4);
    check("fill_level", 64'(fifo_level), 64'd16);
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_valid_%0d", i), 64'(m_axis_tvalid), 64'd1);
      check($sformatf("drain_data_%0d", i),  m_axis_tdata, 64'(i));
      check($sformatf("drain_last_%0d", i),  64'(m_axis_tlast), (i % PLEN == 0) ? 64'd1 : 64'd0);
      step();
    end
    check("drain_empty", 64'(m_axis_tvalid), 64'd0);
    check("drain_tready", 64'(s_axis_tready), 64'd1);

    // ---- 10 events drained continuously: tlast on beats 4 and 8 ----
    do_reset();
    m_axis_tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      s_axis_tvalid = (c < 10);
      s_axis_tdata  = 64'(c + 100);
      if (m_axis_tvalid) begin
        beats++;
        check($sformatf("pkt_data_%0d", beats), m_axis_tdata, 64'(beats + 99));
        check($sformatf("pkt_last_%0d", beats), 64'(m_axis_tlast),
              (beats == 4 || beats == 8) ? 64'd1 : 64'd0);
      end
      step();
    end
    s_axis_tvalid = 1'b0;
    check("pkt_beats", 64'(beats), 64'd10);
    // beat_cnt is now 2: the next two beats end the packet on the second.
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'd7;
    step();
    step();
    s_axis_tvalid = 1'b0;
    check("pkt_cont_last0", 64'(m_axis_tlast), 64'd0);
    m_axis_tready = 1'b1;
    step();
    check("pkt_cont_last1", 64'(m_axis_tlast), 64'd1);
    step();

    // ---- Random sink stalls with 1000 events, scoreboard model ----
    do_reset();
    q.delete();
    occ = 0; sent = 0; drops = 0; beats = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0); cyc++) begin
      s_axis_tvalid = (sent < 1000) && ($urandom_range(0, 99) < 30);
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tuser  = 1'($urandom_range(0, 1));
      m_axis_tready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      if (prev_stall) check("rnd_stall_data", m_axis_tdata, prev_data);
      check("rnd_valid", 64'(m_axis_tvalid), (occ != 0) ? 64'd1 : 64'd0);
      pop = (occ != 0) && m_axis_tready;
      if (pop) begin
        check("rnd_data", m_axis_tdata, q[0]);
        check("rnd_last", 64'(m_axis_tlast), (beats % PLEN == PLEN - 1) ? 64'd1 : 64'd0);
        void'(q.pop_front());
        beats++;
      end
      prev_stall = (occ != 0) && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (s_axis_tvalid) begin
        sent++;
        if (occ < DEPTH) begin
          q.push_back({s_axis_tuser, s_axis_tdata[62:0]});
          occ++;
        end else begin
          drops++;
        end
      end
      if (pop) occ--;
      step();
    end
    s_axis_tvalid = 1'b0;
    check("rnd_drained", 64'(q.size()), 64'd0);
    check("rnd_drops", 64'(drop_count), 64'(drops));
    check("rnd_level", 64'(fifo_level), 64'd0);

    // ---- drop_clear priority against a simultaneous drop ----
    do_reset();
    s_axis_tuser = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(i);
      step();
    end
    check("clr_pre", 64'(drop_count), 64'd3);
    drop_clear = 1'b1;
    step();
    check("clr_with_drop", 64'(drop_count), 64'd1);
    s_axis_tvalid = 1'b0;
    step();
    drop_clear = 1'b0;
    check("clr_alone", 64'(drop_count), 64'd0);
    check("clr_level", 64'(fifo_level), 64'd16);

    // ---- Reset mid-packet ----
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(i);
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(i + 50);
      step();
    end
    s_axis_tvalid = 1'b0;
    check("mid_level_pre", 64'(fifo_level), 64'd5);
    check("mid_last_pre", 64'(m_axis_tlast), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    step();
    aresetn = 1'b1;
    step();
    m_axis_tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      s_axis_tvalid = (c < 4);
      s_axis_tdata  = 64'(c + 200);
      if (m_axis_tvalid) begin
        beats++;
        check($sformatf("mid_data_%0d", beats), m_axis_tdata, 64'(beats + 199));
        check($sformatf("mid_last_%0d", beats), 64'(m_axis_tlast), (beats == 4) ? 64'd1 : 64'd0);
      end
      step();
    end
    s_axis_tvalid = 1'b0;
    check("mid_beats", 64'(beats), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
